rv32im_ctrl_decode: RTL and testbench

- Decode stage control generator for the RV32IM 5-stage pipeline.
- Decodes OPCODE/FUNC3/FUNC7 of the instruction in ID into datapath control signals.
- Registers them so they present to the ID/EX boundary one clock later.
- Illegal or unsupported encodings decode to an all-zero bubble.

---
 rtl/rv32_ctrl_pkg.sv | 38 +++
 rtl/rv32_ctrl_comb.sv | 86 ++++++++
 rtl/rv32im_ctrl_decode.sv | 50 +++++
 tb/tb_rv32im_ctrl_decode.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/rv32_ctrl_pkg.sv
// rtl/rv32_ctrl_pkg.sv - opcode, FUNC7 and immediate-format constants for RV32IM decode
package rv32_ctrl_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [2:0] IMM_I     = 3'b000;
    localparam logic [2:0] IMM_S     = 3'b001;
    localparam logic [2:0] IMM_B     = 3'b010;
    localparam logic [2:0] IMM_U     = 3'b011;
    localparam logic [2:0] IMM_J     = 3'b100;
    localparam logic [2:0] IMM_SHAMT = 3'b101;

    typedef struct packed {
        logic       write_en;
        logic       mem_write;
        logic       mem_read;
        logic       branch;
        logic       jump;
        logic       pc_select;
        logic       imm_select;
        logic       jal_select;
        logic       data_mem_select;
        logic [2:0] imm_pick;
    } ctrl_t;

endpackage

// File: rtl/rv32_ctrl_comb.sv
// rtl/rv32_ctrl_comb.sv - combinational decode table with legality checks
module rv32_ctrl_comb
    import rv32_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] func3,
    input  logic [6:0] func7,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = '0;
        // Illegal encodings fall through with the all-zero default (bubble)
        case (opcode)
            OP_R: begin
                if (func7 == F7_BASE || func7 == F7_MULDIV ||
                    (func7 == F7_ALT && (func3 == 3'b000 || func3 == 3'b101)))
                    ctrl.write_en = 1'b1;
            end
            OP_LOAD: begin
                if (func3 != 3'b011 && func3 != 3'b110 && func3 != 3'b111) begin
                    ctrl.write_en        = 1'b1;
                    ctrl.mem_read        = 1'b1;
                    ctrl.imm_select      = 1'b1;
                    ctrl.data_mem_select = 1'b1;
                    ctrl.imm_pick        = IMM_I;
                end
            end
            OP_IMM: begin
                if ((func3 == 3'b001 && func7 == F7_BASE) ||
                    (func3 == 3'b101 && (func7 == F7_BASE || func7 == F7_ALT))) begin
                    ctrl.write_en   = 1'b1;
                    ctrl.imm_select = 1'b1;
                    ctrl.imm_pick   = IMM_SHAMT;
                end else if (func3 != 3'b001 && func3 != 3'b101) begin
                    ctrl.write_en   = 1'b1;
                    ctrl.imm_select = 1'b1;
                    ctrl.imm_pick   = IMM_I;
                end
            end
            OP_STORE: begin
                if (func3 == 3'b000 || func3 == 3'b001 || func3 == 3'b010) begin
                    ctrl.mem_write  = 1'b1;
                    ctrl.imm_select = 1'b1;
                    ctrl.imm_pick   = IMM_S;
                end
            end
            OP_BRANCH: begin
                if (func3 != 3'b010 && func3 != 3'b011) begin
                    ctrl.branch   = 1'b1;
                    ctrl.imm_pick = IMM_B;
                end
            end
            OP_LUI: begin
                ctrl.write_en   = 1'b1;
                ctrl.imm_select = 1'b1;
                ctrl.imm_pick   = IMM_U;
            end
            OP_AUIPC: begin
                ctrl.write_en   = 1'b1;
                ctrl.pc_select  = 1'b1;
                ctrl.imm_select = 1'b1;
                ctrl.imm_pick   = IMM_U;
            end
            OP_JAL: begin
                ctrl.write_en   = 1'b1;
                ctrl.jump       = 1'b1;
                ctrl.pc_select  = 1'b1;
                ctrl.imm_select = 1'b1;
                ctrl.jal_select = 1'b1;
                ctrl.imm_pick   = IMM_J;
            end
            OP_JALR: begin
                if (func3 == 3'b000) begin
                    ctrl.write_en   = 1'b1;
                    ctrl.jump       = 1'b1;
                    ctrl.imm_select = 1'b1;
                    ctrl.jal_select = 1'b1;
                    ctrl.imm_pick   = IMM_I;
                end
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/rv32im_ctrl_decode.sv
// rtl/rv32im_ctrl_decode.sv - ID-stage control decode registered onto the ID/EX boundary
module rv32im_ctrl_decode
    import rv32_ctrl_pkg::*;
(
    input  logic       CLK,
    input  logic       RESET,
    input  logic [6:0] OPCODE,
    input  logic [2:0] FUNC3,
    input  logic [6:0] FUNC7,
    output logic       WRITE_EN,
    output logic       MEM_WRITE,
    output logic       MEM_READ,
    output logic       BRANCH,
    output logic       JUMP,
    output logic       PC_SELECT,
    output logic       IMM_SELECT,
    output logic       JAL_SELECT,
    output logic       DATA_MEM_SELECT,
    output logic [2:0] IMM_PICK
);

    ctrl_t ctrl_next;
    ctrl_t ctrl_q;

    rv32_ctrl_comb u_comb (
        .opcode (OPCODE),
        .func3  (FUNC3),
        .func7  (FUNC7),
        .ctrl   (ctrl_next)
    );

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET)
            ctrl_q <= '0;
        else
            ctrl_q <= ctrl_next;
    end

    assign WRITE_EN        = ctrl_q.write_en;
    assign MEM_WRITE       = ctrl_q.mem_write;
    assign MEM_READ        = ctrl_q.mem_read;
    assign BRANCH          = ctrl_q.branch;
    assign JUMP            = ctrl_q.jump;
    assign PC_SELECT       = ctrl_q.pc_select;
    assign IMM_SELECT      = ctrl_q.imm_select;
    assign JAL_SELECT      = ctrl_q.jal_select;
    assign DATA_MEM_SELECT = ctrl_q.data_mem_select;
    assign IMM_PICK        = ctrl_q.imm_pick;

endmodule

// File: tb/tb_rv32im_ctrl_decode.sv
// tb/tb_rv32im_ctrl_decode.sv - scoreboard bench for rv32im_ctrl_decode
module tb_rv32im_ctrl_decode;

    // Packed as {WE,MW,MR,BR,JMP,PCS,IMMS,JALS,DMS,IMM_PICK[2:0]}
    localparam logic [11:0] E_ZERO  = 12'b0_0_0_0_0_0_0_0_0_000;
    localparam logic [11:0] E_R     = 12'b1_0_0_0_0_0_0_0_0_000;
    localparam logic [11:0] E_LOAD  = 12'b1_0_1_0_0_0_1_0_1_000;
    localparam logic [11:0] E_IMM   = 12'b1_0_0_0_0_0_1_0_0_000;
    localparam logic [11:0] E_SHAMT = 12'b1_0_0_0_0_0_1_0_0_101;
    localparam logic [11:0] E_STORE = 12'b0_1_0_0_0_0_1_0_0_001;
    localparam logic [11:0] E_BR    = 12'b0_0_0_1_0_0_0_0_0_010;
    localparam logic [11:0] E_LUI   = 12'b1_0_0_0_0_0_1_0_0_011;
    localparam logic [11:0] E_AUIPC = 12'b1_0_0_0_0_1_1_0_0_011;
    localparam logic [11:0] E_JAL   = 12'b1_0_0_0_1_1_1_1_0_100;
    localparam logic [11:0] E_JALR  = 12'b1_0_0_0_1_0_1_1_0_000;

    logic       CLK = 1'b0;
    logic       RESET = 1'b0;
    logic [6:0] OPCODE = 7'b0110011;
    logic [2:0] FUNC3 = 3'b000;
    logic [6:0] FUNC7 = 7'b0000000;
    logic       WRITE_EN, MEM_WRITE, MEM_READ, BRANCH, JUMP;
    logic       PC_SELECT, IMM_SELECT, JAL_SELECT, DATA_MEM_SELECT;
    logic [2:0] IMM_PICK;
    logic [11:0] obs;

    logic [11:0] exp_q[$];
    logic [11:0] last_exp = 12'h000;
    int tests_run = 0;
    int tests_failed = 0;

    rv32im_ctrl_decode dut (
        .CLK             (CLK),
        .RESET           (RESET),
        .OPCODE          (OPCODE),
        .FUNC3           (FUNC3),
        .FUNC7           (FUNC7),
        .WRITE_EN        (WRITE_EN),
        .MEM_WRITE       (MEM_WRITE),
        .MEM_READ        (MEM_READ),
        .BRANCH          (BRANCH),
        .JUMP            (JUMP),
        .PC_SELECT       (PC_SELECT),
        .IMM_SELECT      (IMM_SELECT),
        .JAL_SELECT      (JAL_SELECT),
        .DATA_MEM_SELECT (DATA_MEM_SELECT),
        .IMM_PICK        (IMM_PICK)
    );

    always #5 CLK = ~CLK;

    assign obs = {WRITE_EN, MEM_WRITE, MEM_READ, BRANCH, JUMP, PC_SELECT,
                  IMM_SELECT, JAL_SELECT, DATA_MEM_SELECT, IMM_PICK};

    task automatic check(input string tag, input logic [11:0] got, input logic [11:0] want);
        tests_run++;
        if (got !== want) begin
            tests_failed++;
            $display("FAIL %s got %b required %b", tag, got, want);
        end
    endtask

    // Drive one instruction just after an edge, confirm outputs hold, then score it after the next edge
    task automatic apply(input string tag, input logic [6:0] op, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [11:0] e);
        logic [11:0] want;
        OPCODE = op;
        FUNC3  = f3;
        FUNC7  = f7;
        exp_q.push_back(e);
        #1;
        check({tag, "_hold"}, obs, last_exp);
        @(posedge CLK);
        #1;
        if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, 12'hfff, 12'h000);
        end else begin
            want = exp_q.pop_front();
            check(tag, obs, want);
            last_exp = want;
        end
    endtask

    initial begin
        #2;
        check("reset_async", obs, E_ZERO);
        RESET = 1'b1;
        @(posedge CLK);
        #1;
        check("reset_release_first_edge", obs, E_R);
        last_exp = E_R;

        for (int f = 0; f < 8; f++) begin
            apply("r_base", 7'b0110011, 3'(f), 7'b0000000, E_R);
            apply("r_muldiv", 7'b0110011, 3'(f), 7'b0000001, E_R);
            apply("r_alt", 7'b0110011, 3'(f), 7'b0100000,
                  (f == 0 || f == 5) ? E_R : E_ZERO);
        end
        apply("r_bad_f7", 7'b0110011, 3'b000, 7'b0000010, E_ZERO);

        for (int f = 0; f < 8; f++) begin
            apply("load", 7'b0000011, 3'(f), 7'h5a,
                  (f == 3 || f == 6 || f == 7) ? E_ZERO : E_LOAD);
            apply("store", 7'b0100011, 3'(f), 7'h33, (f <= 2) ? E_STORE : E_ZERO);
            apply("branch", 7'b1100011, 3'(f), 7'h7f,
                  (f == 2 || f == 3) ? E_ZERO : E_BR);
            apply("ialu_f7junk", 7'b0010011, 3'(f), 7'h55,
                  (f == 1 || f == 5) ? E_ZERO : E_IMM);
        end

        apply("nop_addi", 7'b0010011, 3'b000, 7'b0000000, E_IMM);
        apply("slli", 7'b0010011, 3'b001, 7'b0000000, E_SHAMT);
        apply("slli_alt", 7'b0010011, 3'b001, 7'b0100000, E_ZERO);
        apply("srli", 7'b0010011, 3'b101, 7'b0000000, E_SHAMT);
        apply("srai", 7'b0010011, 3'b101, 7'b0100000, E_SHAMT);
        apply("srai_bad", 7'b0010011, 3'b101, 7'b0000001, E_ZERO);

        apply("jal", 7'b1101111, 3'b110, 7'h2c, E_JAL);
        apply("jalr", 7'b1100111, 3'b000, 7'h11, E_JALR);
        apply("jalr_bad", 7'b1100111, 3'b001, 7'h00, E_ZERO);
        apply("lui", 7'b0110111, 3'b011, 7'h7f, E_LUI);
        apply("auipc", 7'b0010111, 3'b100, 7'h40, E_AUIPC);
        apply("op_all_ones", 7'b1111111, 3'b000, 7'h00, E_ZERO);
        apply("op_fence", 7'b0001111, 3'b000, 7'h00, E_ZERO);
        apply("op_system", 7'b1110011, 3'b000, 7'h00, E_ZERO);
        apply("jal_after_bubble", 7'b1101111, 3'b000, 7'h00, E_JAL);

        // Mid-sequence reset, asserted and released between edges
        #2;
        RESET = 1'b0;
        #1;
        check("reset_mid_async", obs, E_ZERO);
        repeat (2) @(posedge CLK);
        #1;
        check("reset_mid_held", obs, E_ZERO);
        RESET = 1'b1;
        last_exp = E_ZERO;
        apply("lui_after_reset", 7'b0110111, 3'b000, 7'h00, E_LUI);
        apply("store_after_reset", 7'b0100011, 3'b010, 7'h00, E_STORE);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got running required finished");
        $fatal(1);
    end

endmodule
